// File: rtl/clk_run_ctrl.sv
// Run/step/halt sequencer for the core clock: programmable tick divider,
// edge-detected controls, registered CoreEn pulse and saturating pulse count.
module clk_run_ctrl #(
   parameter int DIV_W       = 26,
   parameter int DEFAULT_DIV = 10000,
   parameter int CNT_W       = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             DivLoad,
   input  logic [DIV_W-1:0] DivIn,
   input  logic             Run,
   input  logic             Step,
   input  logic             Stop,
   input  logic             CoreHalt,
   output logic             CoreEn,
   output logic             Running,
   output logic             Halted,
   output logic [CNT_W-1:0] CycleCnt
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      STEP = 2'b10,
      HALT = 2'b11
   } stateT;

   stateT            state, stateNext;
   logic [DIV_W-1:0] divCnt, divReg;
   logic             runPrev, stepPrev, stopPrev;
   logic             runEdge, stepEdge, stopEdge;
   logic             tick, coreEnNext;

   // A reload cycle restarts the divider and suppresses its tick
   assign tick     = (divCnt == divReg) && !DivLoad;
   assign runEdge  = Run  & ~runPrev;
   assign stepEdge = Step & ~stepPrev;
   assign stopEdge = Stop & ~stopPrev;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         divCnt <= '0;
         divReg <= DIV_W'(DEFAULT_DIV);
      end else if (DivLoad) begin
         divCnt <= '0;
         divReg <= DivIn;
      end else if (tick) begin
         divCnt <= '0;
      end else begin
         divCnt <= divCnt + DIV_W'(1);
      end
   end

   // History resets high so a level held through reset is not an edge
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         runPrev  <= 1'b1;
         stepPrev <= 1'b1;
         stopPrev <= 1'b1;
      end else begin
         runPrev  <= Run;
         stepPrev <= Step;
         stopPrev <= Stop;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext  = state;
      coreEnNext = 1'b0;
      case (state)
         IDLE: begin
            if (stopEdge)      stateNext = IDLE;
            else if (runEdge)  stateNext = RUN;
            else if (stepEdge) stateNext = STEP;
         end
         RUN: begin
            if (stopEdge)      stateNext = IDLE;
            else if (CoreHalt) stateNext = HALT;
            else if (tick)     coreEnNext = 1'b1;
         end
         STEP: begin
            if (stopEdge) stateNext = IDLE;
            else if (tick) begin
               coreEnNext = 1'b1;
               stateNext  = IDLE;
            end
         end
         HALT: begin
            if (stopEdge) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         CoreEn   <= 1'b0;
         CycleCnt <= '0;
      end else begin
         CoreEn <= coreEnNext;
         if (coreEnNext && (CycleCnt != '1))
            CycleCnt <= CycleCnt + CNT_W'(1);
      end
   end

   assign Running = (state == RUN) || (state == STEP);
   assign Halted  = (state == HALT);

endmodule

// File: tb/tb_clk_run_ctrl.sv
// Scoreboard bench for clk_run_ctrl: a cycle model pushes expected outputs,
// which are popped and compared once the DUT has clocked.
module tb_clk_run_ctrl;

   localparam int DIV_W = 26;
   localparam int CNT_W = 32;
   localparam int DEF   = 10000;

   typedef struct {
      logic             en;
      logic [CNT_W-1:0] cnt;
      logic             running;
      logic             halted;
   } expT;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic             DivLoad = 1'b0;
   logic [DIV_W-1:0] DivIn = '0;
   logic             Run = 1'b0, Step = 1'b0, Stop = 1'b0, CoreHalt = 1'b0;
   logic             CoreEn, Running, Halted;
   logic [CNT_W-1:0] CycleCnt;
   logic             CoreEn4, Running4, Halted4;
   logic [3:0]       CycleCnt4;

   clk_run_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Rst(Rst), .DivLoad(DivLoad), .DivIn(DivIn), .Run(Run),
      .Step(Step), .Stop(Stop), .CoreHalt(CoreHalt), .CoreEn(CoreEn),
      .Running(Running), .Halted(Halted), .CycleCnt(CycleCnt));

   clk_run_ctrl #(.DIV_W(DIV_W), .DEFAULT_DIV(DEF), .CNT_W(4)) dut4 (
      .Clk(Clk), .Rst(Rst), .DivLoad(DivLoad), .DivIn(DivIn), .Run(Run),
      .Step(Step), .Stop(Stop), .CoreHalt(CoreHalt), .CoreEn(CoreEn4),
      .Running(Running4), .Halted(Halted4), .CycleCnt(CycleCnt4));

   always #5 Clk = ~Clk;

   int  nVec = 0, nErr = 0;
   expT sbq[$];

   // reference model state: 0 idle, 1 run, 2 step, 3 halt
   int               mState;
   logic [DIV_W-1:0] mCnt, mDiv;
   logic [CNT_W-1:0] mCyc;
   logic             mRunP, mStepP, mStopP;
   int               pulses;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nVec++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic mReset();
      mState = 0; mCnt = '0; mDiv = DIV_W'(DEF); mCyc = '0;
      mRunP = 1'b1; mStepP = 1'b1; mStopP = 1'b1;
   endtask

   // One clock: model predicts from the current inputs, DUT clocks, compare.
   task automatic cyc();
      expT e, o;
      logic tk, rE, sE, pE, en;
      int   ns;
      tk = !DivLoad && (mCnt == mDiv);
      rE = Run & ~mRunP; sE = Step & ~mStepP; pE = Stop & ~mStopP;
      en = 1'b0; ns = mState;
      case (mState)
         0: if (pE) ns = 0; else if (rE) ns = 1; else if (sE) ns = 2;
         1: if (pE) ns = 0; else if (CoreHalt) ns = 3; else if (tk) en = 1'b1;
         2: if (pE) ns = 0; else if (tk) begin en = 1'b1; ns = 0; end
         default: if (pE) ns = 0;
      endcase
      if (DivLoad) begin mDiv = DivIn; mCnt = '0; end
      else if (tk) mCnt = '0;
      else mCnt = mCnt + 1'b1;
      if (en && mCyc != {CNT_W{1'b1}}) mCyc = mCyc + 1'b1;
      mState = ns; mRunP = Run; mStepP = Step; mStopP = Stop;
      e.en = en; e.cnt = mCyc; e.running = (ns == 1 || ns == 2); e.halted = (ns == 3);
      sbq.push_back(e);
      @(posedge Clk); #1;
      o = sbq.pop_front();
      chk("CoreEn", CoreEn, o.en);
      chk("CycleCnt", CycleCnt, o.cnt);
      chk("Running", Running, o.running);
      chk("Halted", Halted, o.halted);
      if (CoreEn) pulses++;
   endtask

   task automatic doReset();
      Rst = 1'b1; mReset();
      #3 Rst = 1'b0;
   endtask

   initial begin
      mReset();
      #2;
      chk("rst_CoreEn", CoreEn, 0);
      chk("rst_CycleCnt", CycleCnt, 0);
      chk("rst_Running", Running, 0);
      chk("rst_Halted", Halted, 0);
      #10 Rst = 1'b0;

      // 1: divide by 4 in RUN
      DivLoad = 1; DivIn = 3; cyc();
      DivLoad = 0; Run = 1; cyc();
      for (int i = 0; i < 11; i++) cyc();
      chk("t1_cnt", CycleCnt, 3);
      chk("t1_running", Running, 1);

      // 2: single step
      Run = 0; doReset();
      DivLoad = 1; DivIn = 9; cyc();
      DivLoad = 0; Step = 1; cyc();
      pulses = 0;
      for (int i = 0; i < 11; i++) cyc();
      chk("t2_pulses", pulses, 1);
      chk("t2_cnt", CycleCnt, 1);
      chk("t2_running", Running, 0);
      Step = 0; cyc();

      // 3: halt, ignored run edge, stop exits
      DivLoad = 1; DivIn = 3; cyc();
      DivLoad = 0; Run = 1; cyc();
      for (int i = 0; i < 5; i++) cyc();
      CoreHalt = 1; pulses = 0; cyc();
      chk("t3_halted", Halted, 1);
      for (int i = 0; i < 8; i++) cyc();
      Run = 0; cyc();
      Run = 1; cyc();
      chk("t3_pulses", pulses, 0);
      chk("t3_halt_hold", Halted, 1);
      Stop = 1; cyc();
      chk("t3_unhalt", Halted, 0);
      chk("t3_idle", Running, 0);
      CoreHalt = 0; Stop = 0; Run = 0; cyc();

      // 4: run+stop on a tick cycle
      DivLoad = 1; DivIn = 0; cyc();
      DivLoad = 0; Run = 1; cyc();
      cyc(); cyc();
      Run = 0; cyc();
      Run = 1; Stop = 1; cyc();
      chk("t4_noen", CoreEn, 0);
      chk("t4_idle", Running, 0);
      Run = 0; Stop = 0; cyc();

      // 6: 4-bit counter saturates while pulses continue
      doReset();
      DivLoad = 1; DivIn = 0; cyc();
      DivLoad = 0; Run = 1; cyc();
      for (int i = 0; i < 20; i++) cyc();
      chk("t6_cnt4", CycleCnt4, 15);
      chk("t6_en4", CoreEn4, 1);
      chk("t6_cnt32", CycleCnt, 20);

      // 5: async reset between edges, Run held high through release
      #2 Rst = 1'b1; mReset();
      #1;
      chk("t5_en", CoreEn, 0);
      chk("t5_cnt", CycleCnt, 0);
      chk("t5_running", Running, 0);
      #2 Rst = 1'b0;
      cyc(); cyc(); cyc();
      chk("t5_norun", Running, 0);
      Run = 0; cyc();
      Run = 1; cyc();
      begin
         int k = 0;
         pulses = 0;
         while (pulses == 0 && k < 10100) begin
            k++;
            cyc();
         end
         chk("t5_default_div", k, 9996);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule
